// File: rtl/hex_display_scanner.sv
// Two-digit multiplexed seven-segment scanner with a shadow register.
// Loads are committed to the display only at frame boundaries, so a digit never tears mid-scan.
module hex_display_scanner #(
  parameter int unsigned DIV = 1000,
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       dp_in,
  input  logic       lz_blank,
  input  logic       load,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       pending,
  output logic       frame
);

  localparam int unsigned CntMax = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [1:0] {StShow0, StGap0, StShow1, StGap1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      sh_val_q, sh_val_d;
  logic            sh_dp_q, sh_dp_d;
  logic            sh_lz_q, sh_lz_d;
  logic [7:0]      d_val_q, d_val_d;
  logic            d_dp_q, d_dp_d;
  logic            d_lz_q, d_lz_d;
  logic            pending_q, pending_d;
  logic            last_cnt;
  logic            frame_cyc;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_lz_d   = sh_lz_q;
    d_val_d   = d_val_q;
    d_dp_d    = d_dp_q;
    d_lz_d    = d_lz_q;
    pending_d = pending_q;

    if (state_q == StShow0 || state_q == StShow1) begin
      last_cnt = (cnt_q == CntW'(DIV - 1));
    end else begin
      last_cnt = (cnt_q == CntW'(GAP - 1));
    end
    frame_cyc = (state_q == StGap1) && last_cnt;

    if (last_cnt) begin
      cnt_d = '0;
      unique case (state_q)
        StShow0: state_d = StGap0;
        StGap0:  state_d = StShow1;
        StShow1: state_d = StGap1;
        default: state_d = StShow0;
      endcase
    end

    if (load) begin
      sh_val_d  = value;
      sh_dp_d   = dp_in;
      sh_lz_d   = lz_blank;
      pending_d = 1'b1;
    end

    // A load on the commit cycle bypasses the shadow and lands directly on the display.
    if (frame_cyc) begin
      if (load) begin
        d_val_d = value;
        d_dp_d  = dp_in;
        d_lz_d  = lz_blank;
      end else if (pending_q) begin
        d_val_d = sh_val_q;
        d_dp_d  = sh_dp_q;
        d_lz_d  = sh_lz_q;
      end
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StShow0;
      cnt_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= 1'b0;
      sh_lz_q   <= 1'b0;
      d_val_q   <= '0;
      d_dp_q    <= 1'b0;
      d_lz_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_lz_q   <= sh_lz_d;
      d_val_q   <= d_val_d;
      d_dp_q    <= d_dp_d;
      d_lz_q    <= d_lz_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    seg     = 7'h00;
    dp      = 1'b0;
    an      = 2'b00;
    pending = pending_q;
    frame   = frame_cyc;
    unique case (state_q)
      StShow0: begin
        an  = 2'b01;
        seg = hex7(d_val_q[3:0]);
        dp  = d_dp_q;
      end
      StShow1: begin
        an  = 2'b10;
        seg = (d_lz_q && d_val_q[7:4] == 4'h0) ? 7'h00 : hex7(d_val_q[7:4]);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with DIV=4, GAP=2 (12-cycle frame).
// Cycle numbers count from the first cycle after reset release.
module tb_hex_display_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = 8'h00;
  logic       dp_in = 1'b0;
  logic       lz_blank = 1'b0;
  logic       load = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       pending;
  logic       frame;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  hex_display_scanner #(.DIV(4), .GAP(2)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .dp_in(dp_in),
    .lz_blank(lz_blank),
    .load(load),
    .seg(seg),
    .dp(dp),
    .an(an),
    .pending(pending),
    .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic advance_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic pulse_load(input logic [7:0] v, input logic d, input logic lz);
    value    = v;
    dp_in    = d;
    lz_blank = lz;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Expected scan for a display holding lo/hi segment patterns, by frame cycle.
  task automatic chk_scan(input string tag, input logic [6:0] lo, input logic [6:0] hi);
    int p;
    p = cyc % 12;
    if (p < 4) begin
      chk({tag, "_an"}, {6'b0, an}, 8'h01);
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, lo});
    end else if (p >= 6 && p < 10) begin
      chk({tag, "_an"}, {6'b0, an}, 8'h02);
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, hi});
    end else begin
      chk({tag, "_an"}, {6'b0, an}, 8'h00);
      chk({tag, "_seg"}, {1'b0, seg}, 8'h00);
    end
    chk({tag, "_frame"}, {7'b0, frame}, {7'b0, (p == 11)});
  endtask

  initial begin
    // Reset scan
    do_reset();
    chk("rst_an", {6'b0, an}, 8'h01);
    chk("rst_seg", {1'b0, seg}, 8'h3F);
    chk("rst_dp", {7'b0, dp}, 8'h00);
    chk("rst_pending", {7'b0, pending}, 8'h00);
    for (int i = 0; i < 12; i++) begin
      chk_scan("scan", 7'h3F, 7'h3F);
      step();
    end

    // Load mid-frame
    do_reset();
    advance_to(2);
    pulse_load(8'hA5, 1'b1, 1'b0);
    for (int i = 3; i <= 11; i++) begin
      chk("mid_pending", {7'b0, pending}, 8'h01);
      chk_scan("mid_old", 7'h3F, 7'h3F);
      step();
    end
    chk("mid_an", {6'b0, an}, 8'h01);
    chk("mid_seg0", {1'b0, seg}, 8'h6D);
    chk("mid_dp0", {7'b0, dp}, 8'h01);
    chk("mid_pending_clr", {7'b0, pending}, 8'h00);
    advance_to(18);
    chk("mid_an1", {6'b0, an}, 8'h02);
    chk("mid_seg1", {1'b0, seg}, 8'h77);
    chk("mid_dp1", {7'b0, dp}, 8'h00);

    // Last load wins
    do_reset();
    advance_to(1);
    pulse_load(8'h12, 1'b0, 1'b0);
    advance_to(5);
    pulse_load(8'h34, 1'b0, 1'b0);
    advance_to(12);
    for (int i = 0; i < 12; i++) begin
      chk_scan("lastwin", 7'h66, 7'h4F);
      step();
    end

    // Commit-cycle bypass
    do_reset();
    advance_to(11);
    chk("byp_frame", {7'b0, frame}, 8'h01);
    chk("byp_pending0", {7'b0, pending}, 8'h00);
    pulse_load(8'h7E, 1'b0, 1'b0);
    chk("byp_an", {6'b0, an}, 8'h01);
    chk("byp_seg", {1'b0, seg}, 8'h79);
    chk("byp_pending1", {7'b0, pending}, 8'h00);
    advance_to(18);
    chk("byp_seg1", {1'b0, seg}, 8'h07);
    chk("byp_pending2", {7'b0, pending}, 8'h00);

    // Leading-zero blank
    do_reset();
    pulse_load(8'h0C, 1'b0, 1'b1);
    advance_to(12);
    chk("lz_seg0", {1'b0, seg}, 8'h39);
    advance_to(18);
    chk("lz_an1", {6'b0, an}, 8'h02);
    chk("lz_seg1", {1'b0, seg}, 8'h00);
    advance_to(20);
    pulse_load(8'h0C, 1'b0, 1'b0);
    advance_to(30);
    chk("nolz_an1", {6'b0, an}, 8'h02);
    chk("nolz_seg1", {1'b0, seg}, 8'h3F);

    // Reset mid-operation, with a load presented alongside reset
    do_reset();
    advance_to(1);
    pulse_load(8'hFF, 1'b0, 1'b0);
    advance_to(3);
    chk("rmid_pending_before", {7'b0, pending}, 8'h01);
    reset = 1'b1;
    value = 8'hFF;
    load  = 1'b1;
    step();
    reset = 1'b0;
    load  = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 24; i++) begin
      chk("rmid_pending", {7'b0, pending}, 8'h00);
      chk_scan("rmid", 7'h3F, 7'h3F);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on total runtime.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
